// File: rtl/burst_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single BurstRAM command/data port.
// Port 0 is the instruction cache and port 1 is the data cache. Each port can
// hold one pending command. The winner owns the RAM until its burst completes.
`timescale 1ns/1ps
module burst_ram_arbiter #(
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 p0_cmd,
  input  logic                                 p0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        p0_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   p0_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] p0_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   p0_rd_data,
  output logic                                 p0_rd_data_valid,
  output logic                                 p0_wr_ack,
  output logic                                 p0_busy,
  input  logic                                 p1_cmd,
  input  logic                                 p1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        p1_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   p1_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] p1_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   p1_rd_data,
  output logic                                 p1_rd_data_valid,
  output logic                                 p1_wr_ack,
  output logic                                 p1_busy,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
);

  localparam int AW     = RAM_DEPTH_BITWIDTH;
  localparam int CNT_W  = $clog2(RAM_BURST_DATA_COUNT);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, READ, WRITE} state_t;

  state_t               state, state_nx;
  logic [1:0]           pend, pend_cmd;
  logic [1:0][AW-1:0]   pend_addr;
  logic                 grant, last_grant;
  logic                 cur_cmd;
  logic [AW-1:0]        cur_addr;
  logic [CNT_W-1:0]     beat_cnt;

  logic [1:0]           cmd_en_v, cmd_v, busy, wr_ack_v, rd_vld_v;
  logic [1:0][AW-1:0]   addr_v;
  logic                 sel, winner, last_beat, beat_adv;

  assign cmd_en_v = {p1_cmd_en, p0_cmd_en};
  assign cmd_v    = {p1_cmd, p0_cmd};
  assign addr_v   = {p1_addr, p0_addr};

  // A port stays busy while its request waits or while it owns the RAM.
  assign busy[0] = pend[0] | ((state != IDLE) & ~grant);
  assign busy[1] = pend[1] | ((state != IDLE) & grant);
  assign p0_busy = busy[0];
  assign p1_busy = busy[1];

  // Contention goes to the port that did not win last time.
  assign winner    = (&pend) ? ~last_grant : pend[1];
  assign sel       = (state == IDLE) & (|pend) & ~br_busy;
  assign last_beat = (beat_cnt == LAST_BEAT);
  // Write beats are consumed every cycle from ISSUE on; read beats only when valid.
  assign beat_adv  = ((state == ISSUE) & cur_cmd) | (state == WRITE) |
                     ((state == READ) & br_rd_data_valid);

  assign p0_rd_data       = br_rd_data;
  assign p1_rd_data       = br_rd_data;
  assign p0_rd_data_valid = rd_vld_v[0];
  assign p1_rd_data_valid = rd_vld_v[1];
  assign p0_wr_ack        = wr_ack_v[0];
  assign p1_wr_ack        = wr_ack_v[1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and RAM-side/requester-side output steering.
  always_comb begin
    state_nx     = state;
    br_cmd_en    = 1'b0;
    br_cmd       = 1'b0;
    br_addr      = '0;
    br_wr_data   = '0;
    br_data_mask = '0;
    wr_ack_v     = '0;
    rd_vld_v     = '0;
    case (state)
      IDLE: if (sel) state_nx = ISSUE;
      ISSUE: begin
        br_cmd_en = 1'b1;
        br_cmd    = cur_cmd;
        br_addr   = cur_addr;
        if (cur_cmd) begin
          // Beat 0 rides along with the command.
          br_wr_data      = grant ? p1_wr_data : p0_wr_data;
          br_data_mask    = grant ? p1_data_mask : p0_data_mask;
          wr_ack_v[grant] = 1'b1;
          state_nx        = WRITE;
        end else begin
          state_nx = READ;
        end
      end
      WRITE: begin
        br_wr_data      = grant ? p1_wr_data : p0_wr_data;
        br_data_mask    = grant ? p1_data_mask : p0_data_mask;
        wr_ack_v[grant] = 1'b1;
        if (last_beat) state_nx = IDLE;
      end
      READ: begin
        rd_vld_v[grant] = br_rd_data_valid;
        if (br_rd_data_valid && last_beat) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, grant selection and beat counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      pend_cmd   <= '0;
      pend_addr  <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cur_cmd    <= 1'b0;
      cur_addr   <= '0;
      beat_cnt   <= '0;
    end else begin
      // The winner is busy, so a capture never collides with its clear below.
      for (int n = 0; n < 2; n++) begin
        if (cmd_en_v[n] && !busy[n]) begin
          pend[n]      <= 1'b1;
          pend_cmd[n]  <= cmd_v[n];
          pend_addr[n] <= addr_v[n];
        end
      end
      if (sel) begin
        pend[winner] <= 1'b0;
        grant        <= winner;
        last_grant   <= winner;
        cur_cmd      <= pend_cmd[winner];
        cur_addr     <= pend_addr[winner];
      end
      if (beat_adv) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked each cycle by a transaction-level
// model of the arbiter.
`timescale 1ns/1ps
module tb_burst_ram_arbiter;
  localparam int AW = 4, DW = 64, MW = 8, BC = 4;

  logic clk = 1'b0;
  logic rst;
  logic p0_cmd, p0_cmd_en, p1_cmd, p1_cmd_en;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wr_data, p1_wr_data, p0_rd_data, p1_rd_data;
  logic [MW-1:0] p0_data_mask, p1_data_mask;
  logic p0_rd_data_valid, p1_rd_data_valid, p0_wr_ack, p1_wr_ack, p0_busy, p1_busy;
  logic br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_wr_data, br_rd_data;
  logic [MW-1:0] br_data_mask;

  always #5 clk = ~clk;

  burst_ram_arbiter #(.RAM_DEPTH_BITWIDTH(AW), .RAM_BURST_DATA_BITWIDTH(DW),
                      .RAM_BURST_DATA_COUNT(BC)) dut (
    .clk(clk), .rst(rst),
    .p0_cmd(p0_cmd), .p0_cmd_en(p0_cmd_en), .p0_addr(p0_addr),
    .p0_wr_data(p0_wr_data), .p0_data_mask(p0_data_mask),
    .p0_rd_data(p0_rd_data), .p0_rd_data_valid(p0_rd_data_valid),
    .p0_wr_ack(p0_wr_ack), .p0_busy(p0_busy),
    .p1_cmd(p1_cmd), .p1_cmd_en(p1_cmd_en), .p1_addr(p1_addr),
    .p1_wr_data(p1_wr_data), .p1_data_mask(p1_data_mask),
    .p1_rd_data(p1_rd_data), .p1_rd_data_valid(p1_rd_data_valid),
    .p1_wr_ack(p1_wr_ack), .p1_busy(p1_busy),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
  );

  int checks = 0, passes = 0;
  bit chk_en = 0;

  task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- behavioural model ----------------
  // A request table per port plus one "active burst" record.
  bit       m_pv [2];
  bit       m_pc [2];
  logic [AW-1:0] m_pa [2];
  bit       m_act = 0, m_iss = 0, m_cmd = 0;
  int       m_own = 0, m_done = 0, m_last = 1;
  logic [AW-1:0] m_addr = '0;

  always @(negedge clk) begin : model
    logic [1:0] be, rv, ak, cen, cc;
    logic [AW-1:0] ca [2];
    logic ce, bcm;
    logic [AW-1:0] ba;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    logic [255:0] got, exp;
    int w;
    cen = {p1_cmd_en, p0_cmd_en};
    cc  = {p1_cmd, p0_cmd};
    ca[0] = p0_addr; ca[1] = p1_addr;
    be = '0; rv = '0; ak = '0;
    for (int n = 0; n < 2; n++) be[n] = m_pv[n] || (m_act && m_own == n);
    ce  = m_act && m_iss;
    bcm = ce ? m_cmd : 1'b0;
    ba  = ce ? m_addr : '0;
    wd = '0; wm = '0;
    if (m_act && m_cmd) begin
      ak[m_own] = 1'b1;
      wd = (m_own == 1) ? p1_wr_data : p0_wr_data;
      wm = (m_own == 1) ? p1_data_mask : p0_data_mask;
    end
    if (m_act && !m_iss && !m_cmd) rv[m_own] = br_rd_data_valid;
    exp = {be[0], be[1], rv[0], rv[1], ak[0], ak[1], bcm, ce, ba, wd, wm, br_rd_data, br_rd_data};
    got = {p0_busy, p1_busy, p0_rd_data_valid, p1_rd_data_valid, p0_wr_ack, p1_wr_ack,
           br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask, p0_rd_data, p1_rd_data};
    if (chk_en) chk("cycle_model", got, exp);
    // advance model to the next cycle
    if (rst) begin
      m_pv[0] = 0; m_pv[1] = 0; m_act = 0; m_iss = 0; m_done = 0; m_last = 1;
    end else begin
      if (m_act) begin
        if (m_iss) begin
          m_iss = 0;
          m_done = m_cmd ? 1 : 0;
        end else if (m_cmd || br_rd_data_valid) begin
          m_done++;
          if (m_done == BC) m_act = 0;
        end
      end else if ((m_pv[0] || m_pv[1]) && !br_busy) begin
        w = (m_pv[0] && m_pv[1]) ? 1 - m_last : (m_pv[1] ? 1 : 0);
        m_act = 1; m_iss = 1; m_own = w; m_cmd = m_pc[w]; m_addr = m_pa[w];
        m_pv[w] = 0; m_last = w;
      end
      for (int n = 0; n < 2; n++)
        if (cen[n] && !be[n]) begin m_pv[n] = 1; m_pc[n] = cc[n]; m_pa[n] = ca[n]; end
    end
  end

  // ---------------- RAM responder, write-data sources, monitors ----------------
  int rd_left = 0, gap_cnt = 0, gap_cfg = 0, rbeat = 0;
  bit rnd_mode = 0;
  int wbeat [2] = '{0, 0};
  int rd_cnt [2] = '{0, 0};
  logic [DW-1:0] last_rd [2];
  int cyc = 0, last_rd_cyc0 = 0;
  int issue_cyc [$];
  logic issue_cmd [$];
  logic [AW-1:0] issue_addr [$];

  initial begin : env
    logic a0, a1;
    forever begin
      @(negedge clk);
      cyc++;
      if (br_cmd_en === 1'b1) begin
        issue_cyc.push_back(cyc); issue_cmd.push_back(br_cmd); issue_addr.push_back(br_addr);
        if (br_cmd === 1'b0) begin rd_left += BC; rbeat = 0; end
      end
      if (p0_rd_data_valid === 1'b1) begin rd_cnt[0]++; last_rd[0] = p0_rd_data; last_rd_cyc0 = cyc; end
      if (p1_rd_data_valid === 1'b1) begin rd_cnt[1]++; last_rd[1] = p1_rd_data; end
      a0 = (p0_wr_ack === 1'b1); a1 = (p1_wr_ack === 1'b1);
      @(posedge clk); #1;
      if (a0) wbeat[0] = (wbeat[0] + 1) % BC;
      if (a1) wbeat[1] = (wbeat[1] + 1) % BC;
      p0_wr_data   = 64'hC0 + 64'(wbeat[0]);
      p0_data_mask = 8'h0F ^ 8'(wbeat[0]);
      p1_wr_data   = 64'hB0 + 64'(wbeat[1]);
      p1_data_mask = 8'hFF;
      br_rd_data_valid = 1'b0;
      if (rd_left > 0) begin
        if (gap_cnt > 0) gap_cnt--;
        else begin
          br_rd_data_valid = 1'b1;
          br_rd_data = 64'hA0 + 64'(rbeat);
          rbeat++; rd_left--;
          gap_cnt = rnd_mode ? int'($urandom_range(0, 2)) : gap_cfg;
        end
      end else if (rnd_mode && $urandom_range(0, 7) == 0) begin
        br_rd_data_valid = 1'b1;
        br_rd_data = {$urandom, $urandom};
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic req(int p, logic c, logic [AW-1:0] a);
    if (p == 0) begin p0_cmd_en = 1; p0_cmd = c; p0_addr = a; end
    else        begin p1_cmd_en = 1; p1_cmd = c; p1_addr = a; end
    tick();
    p0_cmd_en = 0; p1_cmd_en = 0;
  endtask

  task automatic wait_idle(int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (p0_busy === 1'b0 && p1_busy === 1'b0) ok = 1;
    end
    chk("idle_within_budget", ok, 1);
    tick();
  endtask

  initial begin : stim
    int r0, r1, nq;
    rst = 1; br_busy = 0; br_rd_data_valid = 0; br_rd_data = '0;
    p0_cmd = 0; p0_cmd_en = 0; p0_addr = '0; p1_cmd = 0; p1_cmd_en = 0; p1_addr = '0;
    p0_wr_data = '0; p1_wr_data = '0; p0_data_mask = '0; p1_data_mask = '0;
    repeat (3) tick();
    rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_outputs", {p0_busy, p1_busy, p0_rd_data_valid, p1_rd_data_valid,
                          p0_wr_ack, p1_wr_ack, br_cmd, br_cmd_en, br_addr}, '0);
    tick();

    // single read on port 0
    r0 = rd_cnt[0]; r1 = rd_cnt[1];
    req(0, 0, 4'd3);
    @(negedge clk);
    chk("rd_busy_T1", {p0_busy, br_cmd_en}, 2'b10);
    @(negedge clk);
    chk("rd_issue_T2", {br_cmd_en, br_cmd, br_addr}, {1'b1, 1'b0, 4'd3});
    wait_idle(50);
    chk("rd_beats_p0", rd_cnt[0] - r0, 4);
    chk("rd_last_data", last_rd[0], 64'hA3);
    chk("rd_none_p1", rd_cnt[1] - r1, 0);

    // single write on port 1
    req(1, 1, 4'd5);
    @(negedge clk);
    @(negedge clk);
    chk("wr_issue", {br_cmd_en, br_cmd, br_addr}, {1'b1, 1'b1, 4'd5});
    for (int k = 0; k < BC; k++) begin
      if (k > 0) @(negedge clk);
      chk("wr_beat", {p1_wr_ack, br_data_mask, br_wr_data}, {1'b1, 8'hFF, 64'hB0 + 64'(k)});
    end
    @(negedge clk);
    chk("wr_done", {p1_wr_ack, p1_busy}, 2'b00);
    tick();

    // simultaneous: p0 read + p1 write
    nq = issue_cyc.size();
    p0_cmd_en = 1; p0_cmd = 0; p0_addr = 4'd1;
    p1_cmd_en = 1; p1_cmd = 1; p1_addr = 4'd2;
    tick();
    p0_cmd_en = 0; p1_cmd_en = 0;
    wait_idle(100);
    chk("sim_order", {issue_cmd[nq], issue_cmd[nq+1]}, 2'b01);
    chk("sim_reissue_gap", issue_cyc[nq+1] - last_rd_cyc0, 2);

    // round-robin: after a lone p0 burst, contention goes to p1
    req(0, 0, 4'd6);
    wait_idle(50);
    nq = issue_cyc.size();
    p0_cmd_en = 1; p0_cmd = 0; p0_addr = 4'd7;
    p1_cmd_en = 1; p1_cmd = 0; p1_addr = 4'd8;
    tick();
    p0_cmd_en = 0; p1_cmd_en = 0;
    wait_idle(100);
    chk("rr_order", {issue_addr[nq], issue_addr[nq+1]}, {4'd8, 4'd7});

    // br_busy gating
    nq = issue_cyc.size();
    br_busy = 1;
    req(0, 0, 4'd2);
    repeat (4) tick();
    br_busy = 0;
    @(negedge clk);
    chk("busy_gate_hold", {32'(issue_cyc.size() - nq), 1'b0, br_cmd_en}, {32'd0, 2'b00});
    @(negedge clk);
    chk("busy_gate_release", {br_cmd_en, br_addr}, {1'b1, 4'd2});
    wait_idle(50);

    // ignored second pulse while busy, read beats with gaps
    gap_cfg = 2;
    nq = issue_cyc.size(); r0 = rd_cnt[0];
    req(0, 0, 4'd4);
    p0_cmd_en = 1; p0_cmd = 1; p0_addr = 4'd9;
    tick();
    p0_cmd_en = 0;
    wait_idle(100);
    chk("ignore_addr", {issue_addr[nq], issue_cmd[nq]}, {4'd4, 1'b0});
    chk("ignore_single_burst", issue_cyc.size() - nq, 1);
    chk("gap_beats", rd_cnt[0] - r0, 4);

    // reset mid-read after two beats
    gap_cfg = 3;
    r0 = rd_cnt[0];
    req(0, 0, 4'd1);
    for (int i = 0; i < 100 && (rd_cnt[0] - r0) < 2; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_mid_outputs", {p0_busy, p1_busy, p0_rd_data_valid, p1_rd_data_valid,
                            p0_wr_ack, p1_wr_ack, br_cmd, br_cmd_en, br_addr}, '0);
    repeat (12) tick();
    chk("rst_beats_dropped", rd_cnt[0] - r0, 2);
    gap_cfg = 0;
    r1 = rd_cnt[1];
    req(1, 0, 4'hC);
    wait_idle(100);
    chk("post_rst_p1_read", rd_cnt[1] - r1, 4);

    // randomized traffic
    rnd_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      p0_cmd_en = ($urandom_range(0, 4) == 0); p0_cmd = 1'($urandom); p0_addr = 4'($urandom);
      p1_cmd_en = ($urandom_range(0, 4) == 0); p1_cmd = 1'($urandom); p1_addr = 4'($urandom);
      br_busy = ($urandom_range(0, 3) == 0);
      tick();
    end
    p0_cmd_en = 0; p1_cmd_en = 0; br_busy = 0;
    wait_idle(200);
    rnd_mode = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Shares one BurstRAM command/data port between two cache requesters: port 0 (instruction cache) and port 1 (data cache).
- Captures one pending command per port and grants the RAM round-robin.
- Issues the burst command, then steers read beats back to the owner or forwards write beats from it.
- Releases the grant when the burst completes; sits between the caches and the BurstRAM.

Parameters:
- RAM_DEPTH_BITWIDTH, 4, BurstRAM address width.
- RAM_BURST_DATA_BITWIDTH, 64, bits per beat; divisible by 8.
- RAM_BURST_DATA_COUNT, 4, beats per burst; power of two, at least 2.

Ports:
- clk  in  1  single clock for requesters, arbiter and RAM interface.
- rst  in  1  synchronous, active-high reset.
- pN_cmd  in  1  N=0,1; 0=read, 1=write; sampled with pN_cmd_en.
- pN_cmd_en  in  1  one-cycle request pulse; legal only while pN_busy=0.
- pN_addr  in  RAM_DEPTH_BITWIDTH  burst address; sampled with pN_cmd_en.
- pN_wr_data  in  RAM_BURST_DATA_BITWIDTH  current write beat; muxed live to br_wr_data while granted.
- pN_data_mask  in  RAM_BURST_DATA_BITWIDTH/8  current write beat mask; muxed live.
- pN_rd_data  out  RAM_BURST_DATA_BITWIDTH  read beat; equals br_rd_data.
- pN_rd_data_valid  out  1  read beat valid for port N.
- pN_wr_ack  out  1  current write beat consumed; requester advances to the next beat.
- pN_busy  out  1  request pending or in progress.
- br_cmd  out  1  to BurstRAM.
- br_cmd_en  out  1  to BurstRAM.
- br_addr  out  RAM_DEPTH_BITWIDTH  to BurstRAM.
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  to BurstRAM.
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  to BurstRAM.
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH  from BurstRAM.
- br_rd_data_valid  in  1  from BurstRAM.
- br_busy  in  1  from BurstRAM.

Behaviour:
- Reset values: all pN_busy, pN_rd_data_valid, pN_wr_ack, br_cmd, br_cmd_en, br_addr = 0. Pending flags cleared. last_grant=1, so port 0 wins first. beat_cnt=0. State=IDLE.
- Capture: pN_cmd_en=1 with pN_busy=0 at cycle T latches cmd/addr into pending[N]; pN_busy=1 from T+1.
- pN_cmd_en while pN_busy=1 is ignored; the latched request is unchanged.
- States and transitions:
  - IDLE -> ISSUE when any pending and br_busy=0.
  - ISSUE -> READ if the granted cmd is 0; ISSUE -> WRITE if it is 1.
  - READ -> IDLE after the final beat; WRITE -> IDLE after the final beat.
- Winner selection in IDLE:
  - Only one port pending: that port wins.
  - Both pending: the port != last_grant wins.
  - On the selection cycle, grant and last_grant are updated and the winner's pending flag is cleared.
- ISSUE (1 cycle): br_cmd_en=1, br_cmd/br_addr from the latched request.
  - Write: beat 0 is driven on br_wr_data/br_data_mask in this same cycle, and pN_wr_ack=1.
  - Read: br_wr_data=0, br_data_mask=0.
- WRITE: br_wr_data/br_data_mask = granted port's inputs (combinational mux), pN_wr_ack=1 each cycle.
  - Exactly RAM_BURST_DATA_COUNT acks per write burst, counting the ISSUE cycle.
  - Final ack at ISSUE+RAM_BURST_DATA_COUNT-1; pN_busy=0 the cycle after.
- READ: pN_rd_data_valid = br_rd_data_valid for the granted port only, same cycle (combinational path).
  - beat_cnt counts valid beats and wraps to 0 after RAM_BURST_DATA_COUNT-1.
  - pN_busy=0 the cycle after the final beat.
  - Non-valid gaps between beats are tolerated.
- br_rd_data_valid in IDLE/ISSUE/WRITE, or for the non-granted port, is dropped.
- A port whose busy clears at T may pulse cmd_en at T; it is captured normally.
- Grant is held until the burst completes, with no preemption. A port releasing a burst cannot win again while the other port is pending.
- br_busy=1 in IDLE blocks issue; pending requests wait.
- br_busy is ignored once ISSUE starts.
- rst mid-burst: everything returns to reset values next cycle. The in-flight burst is abandoned and its late rd_data_valid beats are dropped.
- Latency from cmd_en to br_cmd_en, uncontended with br_busy=0: 2 cycles (capture, select, issue).

Test Plan:
- Single read: p0 read addr=3 -> br_cmd_en=1 at T+2 with br_addr=3, br_cmd=0. Four br_rd_data_valid beats 0xA0..0xA3 appear on p0_rd_data with p0_rd_data_valid. p1_rd_data_valid stays 0. p0_busy=0 after the 4th beat.
- Single write: p1 write addr=5 -> br_cmd_en with br_cmd=1. p1_wr_ack high 4 consecutive cycles starting at the issue cycle. br_wr_data tracks p1_wr_data beats 0xB0..0xB3 and mask 0xFF.
- Simultaneous requests: p0 read and p1 write in the same cycle -> p0 is served first. p1 is issued in the cycle after IDLE re-selects, following p0's last beat. Then p0 read + p1 read again -> p1 first (round-robin).
- br_busy gating: br_busy=1 for 5 cycles while p0 is pending -> no br_cmd_en. br_cmd_en occurs 1 cycle after br_busy falls.
- Protocol violation and gaps: p0_cmd_en pulsed again while p0_busy=1 with addr=9 -> ignored, original addr kept. Read beats with 2-cycle gaps -> still 4 beats forwarded, busy drops only after the 4th.
- Reset mid-read after 2 beats -> all outputs 0. The remaining 2 beats are not forwarded. A fresh p1 request afterwards completes normally.
